// File: rtl/ledr_pwm_driver.sv
`timescale 1ns/1ps
// ledr_pwm_driver: 16-phase PWM dimmer and blinker for the 10 board LEDs.
//
// Ports
//   clk         clock, all logic on rising edge
//   reset_n     asynchronous active-low reset
//   pattern     LED enable word (LEDR PIO out_port)
//   brightness  global duty level 0..15
//   blink_en    1 = enabled LEDs blink, 0 = steady
//   led         registered LED drive, active-high
//   frame_tick  registered one-cycle pulse after each PWM frame boundary
//
// Parameters
//   PRESCALE      clk cycles per PWM step (2..65535)
//   BLINK_FRAMES  PWM frames per blink half-period (1..1023)
//
// Build option
//   LEDR_PWM_FADE_EN  when defined, the shadow brightness ramps one step per
//                     frame toward the brightness input instead of loading it.
module ledr_pwm_driver #(
  parameter int unsigned PRESCALE     = 256,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] pattern,
  input  logic [3:0] brightness,
  input  logic       blink_en,
  output logic [9:0] led,
  output logic       frame_tick
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc;
  logic [3:0]    phase;
  logic [FW-1:0] frame_cnt;
  logic          blink_state;
  logic [9:0]    sh_pattern;
  logic [3:0]    sh_bright;
  logic          sh_blink_en;

  logic          step_tick_c;
  logic          frame_bnd_c;
  logic          duty_on_c;
  logic          blink_on_c;
  logic [3:0]    sh_bright_nxt_c;

  assign step_tick_c = (presc == PRESC_MAX);
  assign frame_bnd_c = step_tick_c && (phase == 4'd15);

  // Level 15 lights every phase; otherwise lit for the first sh_bright phases.
  assign duty_on_c = (sh_bright == 4'd15) || (phase < sh_bright);

  // Steady mode overrides the blink phase without waiting for a register update.
  assign blink_on_c = blink_state || !sh_blink_en;

`ifdef LEDR_PWM_FADE_EN
  // Ramp one level per frame toward the requested brightness.
  always_comb begin
    sh_bright_nxt_c = sh_bright;
    if (sh_bright < brightness) begin
      sh_bright_nxt_c = sh_bright + 4'd1;
    end else if (sh_bright > brightness) begin
      sh_bright_nxt_c = sh_bright - 4'd1;
    end
  end
`else
  assign sh_bright_nxt_c = brightness;
`endif

  // Prescaler and PWM phase counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      phase <= '0;
    end else begin
      presc <= step_tick_c ? '0 : presc + PW'(1);
      if (step_tick_c) begin
        phase <= phase + 4'd1;
      end
    end
  end

  // Shadow registers reload only at a frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_pattern  <= '0;
      sh_bright   <= '0;
      sh_blink_en <= 1'b0;
    end else if (frame_bnd_c) begin
      sh_pattern  <= pattern;
      sh_bright   <= sh_bright_nxt_c;
      sh_blink_en <= blink_en;
    end
  end

  // Blink half-period counter; held in the on state while blinking is off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      blink_state <= 1'b1;
    end else if (!sh_blink_en) begin
      frame_cnt   <= '0;
      blink_state <= 1'b1;
    end else if (frame_bnd_c) begin
      if (frame_cnt == FRAME_MAX) begin
        frame_cnt   <= '0;
        blink_state <= !blink_state;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led        <= '0;
      frame_tick <= 1'b0;
    end else begin
      led        <= sh_pattern & {10{duty_on_c && blink_on_c}};
      frame_tick <= frame_bnd_c;
    end
  end

endmodule

// File: tb/tb_ledr_pwm_driver.sv
`timescale 1ns/1ps
// Directed bench for ledr_pwm_driver with PRESCALE=4, BLINK_FRAMES=2 (64-cycle frame).
// Per-frame expectations are queued before each frame and compared after it.
module tb_ledr_pwm_driver;

  localparam int unsigned PRESCALE     = 4;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int          FRAME        = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] pattern;
  logic [3:0] brightness;
  logic       blink_en;
  logic [9:0] led;
  logic       frame_tick;

  int total = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    int         on_cnt;
    logic [9:0] or_val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ledr_pwm_driver #(
    .PRESCALE    (PRESCALE),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pattern   (pattern),
    .brightness(brightness),
    .blink_en  (blink_en),
    .led       (led),
    .frame_tick(frame_tick)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input string tag, input int on_cnt, input logic [9:0] or_val);
    exp_t e;
    e.tag    = tag;
    e.on_cnt = on_cnt;
    e.or_val = or_val;
    sb.push_back(e);
  endtask

  // Observe one frame window (ends on the next frame_tick sample); optionally
  // change inputs after sample chg_at.
  task automatic measure(input int chg_at, input logic [9:0] np, input logic [3:0] nb,
                         input logic nbl);
    int         on_cnt = 0;
    int         ft_pos = 0;
    int         ft_cnt = 0;
    logic [9:0] orv    = '0;
    exp_t       e;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (led != 10'h000) on_cnt++;
      orv |= led;
      if (frame_tick) begin
        ft_cnt++;
        if (ft_pos == 0) ft_pos = k;
      end
      if (k == chg_at) begin
        pattern    = np;
        brightness = nb;
        blink_en   = nbl;
      end
    end
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_on_cycles"}, on_cnt, e.on_cnt);
      check({e.tag, "_led_or"}, int'(orv), int'(e.or_val));
      check({e.tag, "_tick_pos"}, (ft_cnt == 1) ? ft_pos : -ft_cnt, FRAME);
    end
  endtask

  // Count cycles from reset release to the first frame_tick; led must stay dark.
  task automatic wait_first_tick(input string tag);
    int         n   = 0;
    logic [9:0] orv = '0;
    do begin
      @(negedge clk);
      n++;
      orv |= led;
    end while (!frame_tick && n < 4 * FRAME);
    check({tag, "_first_tick"}, n, FRAME);
    check({tag, "_led_dark"}, int'(orv), 0);
  endtask

  initial begin
    pattern    = 10'h3FF;
    brightness = 4'd15;
    blink_en   = 1'b0;
    reset_n    = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_led", int'(led), 0);
    check("rst_tick", int'(frame_tick), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_first_tick("rst");

    // Full brightness, steady.
    expect_frame("full_f1", 64, 10'h3FF);
    measure(-1, pattern, brightness, blink_en);
    expect_frame("full_f2", 64, 10'h3FF);
    measure(-1, pattern, brightness, blink_en);

    // New settings apply only from the following frame.
    pattern    = 10'h001;
    brightness = 4'd4;
    expect_frame("late_load", 64, 10'h3FF);
    measure(-1, pattern, brightness, blink_en);
    expect_frame("duty4", 16, 10'h001);
    measure(-1, pattern, brightness, blink_en);

    // Mid-frame pattern change.
    pattern    = 10'h0F0;
    brightness = 4'd15;
    expect_frame("duty4_hold", 16, 10'h001);
    measure(-1, pattern, brightness, blink_en);
    expect_frame("pat_mid", 64, 10'h0F0);
    measure(20, 10'h00F, 4'd15, 1'b0);
    pattern  = 10'h3FF;
    blink_en = 1'b1;
    expect_frame("pat_new", 64, 10'h00F);
    measure(-1, pattern, brightness, blink_en);

    // Blink: two frames on, two off; disable during an off frame.
    expect_frame("blink_on1", 64, 10'h3FF);
    measure(-1, pattern, brightness, blink_en);
    expect_frame("blink_on2", 64, 10'h3FF);
    measure(-1, pattern, brightness, blink_en);
    expect_frame("blink_off1", 0, 10'h000);
    measure(-1, pattern, brightness, blink_en);
    expect_frame("blink_off2", 0, 10'h000);
    measure(20, 10'h3FF, 4'd15, 1'b0);
    expect_frame("blink_resume", 64, 10'h3FF);
    measure(-1, pattern, brightness, blink_en);

    // Asynchronous reset while lit and while frame_tick is high.
    check("pre_rst_led", int'(led), 10'h3FF);
    check("pre_rst_tick", int'(frame_tick), 1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_led", int'(led), 0);
    check("mid_rst_tick", int'(frame_tick), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_first_tick("rst2");
    expect_frame("post_rst", 64, 10'h3FF);
    measure(-1, pattern, brightness, blink_en);

`ifdef LEDR_PWM_FADE_EN
    // Fade from 0 to 15, one level per frame.
    pattern    = 10'h001;
    brightness = 4'd15;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_first_tick("fade_rst");
    for (int lvl = 1; lvl <= 15; lvl++) begin
      expect_frame($sformatf("fade%0d", lvl), (lvl == 15) ? 64 : 4 * lvl, 10'h001);
      measure(-1, pattern, brightness, blink_en);
    end
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
